// File: rtl/hazard_controller_if.sv
// rtl/hazard_controller_if.sv - ID/EX/MEM side signals between the pipeline and the hazard controller
//   slave  (controller): takes id_* decode info, ex_taken, dm_req/dm_ready;
//                        drives pipeline enables/flushes, fwd_a/fwd_b, mem_err, stall_cycles
//   master (pipeline)  : the opposite directions
interface hazard_controller_if #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
);
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_use_rs1;
   logic                  id_use_rs2;
   logic [REG_ADDR_W-1:0] id_rd;
   logic                  id_ruwr;
   logic                  id_load;
   logic                  ex_taken;
   logic                  dm_req;
   logic                  dm_ready;
   logic                  pc_en;
   logic                  ifid_en;
   logic                  ifid_flush;
   logic                  idex_en;
   logic                  idex_bubble;
   logic                  exmem_en;
   logic                  memwb_en;
   logic [1:0]            fwd_a;
   logic [1:0]            fwd_b;
   logic                  mem_err;
   logic [CNT_W-1:0]      stall_cycles;

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_ruwr, id_load,
             ex_taken, dm_req, dm_ready,
      output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en,
             fwd_a, fwd_b, mem_err, stall_cycles
   );

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_ruwr, id_load,
             ex_taken, dm_req, dm_ready,
      input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en,
             fwd_a, fwd_b, mem_err, stall_cycles
   );
endinterface

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - forwarding, load-use stall, branch flush and memory-wait freeze for a 5-stage RV32I pipeline
//   clk, rst : clock and synchronous active-high reset
//   hz       : hazard_controller_if.slave (ID decode info in, pipeline enables/flushes/forward selects out)
module hazard_controller #(
   parameter int REG_ADDR_W = 5,
   parameter int MAX_WAIT   = 15,
   parameter int CNT_W      = 32
) (
   input  logic                clk,
   input  logic                rst,
   hazard_controller_if.slave  hz
);
   typedef enum logic [1:0] {ST_RUN, ST_MEMWAIT, ST_ERR} state_e;

   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   state_e                state_q, state_d;
   logic [7:0]            wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]      stall_q, stall_d;

   // Shadow copy of register usage for the instructions in EX, MEM and WB.
   logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d, ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
   logic                  ex_wr_q, ex_wr_d, ex_ld_q, ex_ld_d;
   logic                  ex_use1_q, ex_use1_d, ex_use2_q, ex_use2_d;
   logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
   logic                  mem_wr_q, mem_wr_d, wb_wr_q, wb_wr_d;

   logic       frozen, load_use, id_wr;
   logic       pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en;
   logic [1:0] fwd_a, fwd_b;

   always_comb begin
      // In MEMWAIT the access is still open until dm_ready, whatever dm_req does.
      frozen = (state_q == ST_ERR)
             || (state_q == ST_MEMWAIT && !hz.dm_ready)
             || (state_q == ST_RUN && hz.dm_req && !hz.dm_ready);
      load_use = hz.id_valid && ex_ld_q && ex_wr_q
               && ((hz.id_use_rs1 && hz.id_rs1 == ex_rd_q)
                || (hz.id_use_rs2 && hz.id_rs2 == ex_rd_q));
      // A write to x0 is dropped at capture so it can never forward or stall.
      id_wr = hz.id_ruwr && (hz.id_rd != '0);

      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_en     = 1'b1;
      idex_bubble = 1'b0;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      if (rst) begin
         {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (frozen) begin
         {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
      end else if (hz.ex_taken) begin
         // Flush wins over load-use: the stalled instruction is squashed anyway.
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (load_use) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_bubble = 1'b1;
      end

      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (!rst) begin
         if (ex_use1_q && mem_wr_q && mem_rd_q == ex_rs1_q)     fwd_a = 2'b10;
         else if (ex_use1_q && wb_wr_q && wb_rd_q == ex_rs1_q)  fwd_a = 2'b01;
         if (ex_use2_q && mem_wr_q && mem_rd_q == ex_rs2_q)     fwd_b = 2'b10;
         else if (ex_use2_q && wb_wr_q && wb_rd_q == ex_rs2_q)  fwd_b = 2'b01;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         ST_RUN: begin
            if (hz.dm_req && !hz.dm_ready) begin
               state_d    = ST_MEMWAIT;
               wait_cnt_d = 8'd1;
            end
         end
         ST_MEMWAIT: begin
            if (hz.dm_ready) begin
               state_d    = ST_RUN;
               wait_cnt_d = 8'd0;
            end else if (wait_cnt_q == MAX_WAIT_C) begin
               state_d = ST_ERR;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         default: state_d = ST_ERR;
      endcase

      stall_d = stall_q;
      if (!pc_en && stall_q != '1) stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};

      ex_rd_d   = ex_rd_q;   ex_rs1_d  = ex_rs1_q;  ex_rs2_d = ex_rs2_q;
      ex_wr_d   = ex_wr_q;   ex_ld_d   = ex_ld_q;
      ex_use1_d = ex_use1_q; ex_use2_d = ex_use2_q;
      mem_rd_d  = mem_rd_q;  mem_wr_d  = mem_wr_q;
      wb_rd_d   = wb_rd_q;   wb_wr_d   = wb_wr_q;
      if (!frozen) begin
         wb_rd_d  = mem_rd_q;
         wb_wr_d  = mem_wr_q;
         mem_rd_d = ex_rd_q;
         mem_wr_d = ex_wr_q;
         ex_rd_d  = hz.id_rd;
         ex_rs1_d = hz.id_rs1;
         ex_rs2_d = hz.id_rs2;
         if (hz.id_valid && !idex_bubble) begin
            ex_wr_d   = id_wr;
            ex_ld_d   = hz.id_load && id_wr;
            ex_use1_d = hz.id_use_rs1;
            ex_use2_d = hz.id_use_rs2;
         end else begin
            {ex_wr_d, ex_ld_d, ex_use1_d, ex_use2_d} = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= '0;
         stall_q    <= '0;
         ex_rd_q    <= '0; ex_rs1_q <= '0; ex_rs2_q <= '0;
         ex_wr_q    <= 1'b0; ex_ld_q <= 1'b0; ex_use1_q <= 1'b0; ex_use2_q <= 1'b0;
         mem_rd_q   <= '0; mem_wr_q <= 1'b0;
         wb_rd_q    <= '0; wb_wr_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         stall_q    <= stall_d;
         ex_rd_q    <= ex_rd_d; ex_rs1_q <= ex_rs1_d; ex_rs2_q <= ex_rs2_d;
         ex_wr_q    <= ex_wr_d; ex_ld_q <= ex_ld_d; ex_use1_q <= ex_use1_d; ex_use2_q <= ex_use2_d;
         mem_rd_q   <= mem_rd_d; mem_wr_q <= mem_wr_d;
         wb_rd_q    <= wb_rd_d;  wb_wr_q  <= wb_wr_d;
      end
   end

   assign hz.pc_en        = pc_en;
   assign hz.ifid_en      = ifid_en;
   assign hz.ifid_flush   = ifid_flush;
   assign hz.idex_en      = idex_en;
   assign hz.idex_bubble  = idex_bubble;
   assign hz.exmem_en     = exmem_en;
   assign hz.memwb_en     = memwb_en;
   assign hz.fwd_a        = fwd_a;
   assign hz.fwd_b        = fwd_b;
   assign hz.mem_err      = !rst && (state_q == ST_ERR);
   assign hz.stall_cycles = stall_q;
endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - self-checking bench for hazard_controller
module tb_hazard_controller;
   // ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en}
   localparam logic [6:0] RST  = 7'b0010100;
   localparam logic [6:0] NORM = 7'b1101011;
   localparam logic [6:0] LU   = 7'b0001111;
   localparam logic [6:0] FL   = 7'b1111111;
   localparam logic [6:0] FRZ  = 7'b0000000;

   typedef struct {
      logic       rst, valid;
      logic [4:0] rs1, rs2;
      logic       u1, u2;
      logic [4:0] rd;
      logic       wr, ld, taken, req, rdy;
      logic [6:0] ctl;
      logic [1:0] fa, fb;
      int         err;    // -1: not checked
      int         stall;  // -1: not checked
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t exp_q[$];
   vec_t tbl[$];

   always #5 clk = ~clk;

   hazard_controller_if #(.REG_ADDR_W(5), .CNT_W(32)) hz ();

   hazard_controller #(.REG_ADDR_W(5), .MAX_WAIT(15), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   function automatic vec_t mk(input bit r, input bit va, input int s1, input int s2,
                               input bit u1, input bit u2, input int d, input bit w,
                               input bit l, input bit tk, input bit rq, input bit ry,
                               input logic [6:0] c, input int a, input int b,
                               input int e, input int st);
      vec_t v;
      v.rst = r; v.valid = va; v.rs1 = s1[4:0]; v.rs2 = s2[4:0];
      v.u1 = u1; v.u2 = u2; v.rd = d[4:0]; v.wr = w; v.ld = l;
      v.taken = tk; v.req = rq; v.rdy = ry;
      v.ctl = c; v.fa = a[1:0]; v.fb = b[1:0]; v.err = e; v.stall = st;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic step(input vec_t v, input string name);
      vec_t e;
      rst           = v.rst;
      hz.id_valid   = v.valid;
      hz.id_rs1     = v.rs1;
      hz.id_rs2     = v.rs2;
      hz.id_use_rs1 = v.u1;
      hz.id_use_rs2 = v.u2;
      hz.id_rd      = v.rd;
      hz.id_ruwr    = v.wr;
      hz.id_load    = v.ld;
      hz.ex_taken   = v.taken;
      hz.dm_req     = v.req;
      hz.dm_ready   = v.rdy;
      exp_q.push_back(v);
      @(negedge clk);
      e = exp_q.pop_front();
      check({name, ".ctl"}, 32'({hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_en,
                                 hz.idex_bubble, hz.exmem_en, hz.memwb_en}), 32'(e.ctl));
      check({name, ".fwd_a"}, 32'(hz.fwd_a), 32'(e.fa));
      check({name, ".fwd_b"}, 32'(hz.fwd_b), 32'(e.fb));
      if (e.err >= 0)   check({name, ".mem_err"}, 32'(hz.mem_err), 32'(e.err));
      if (e.stall >= 0) check({name, ".stall_cycles"}, hz.stall_cycles, 32'(e.stall));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      hz.id_valid = 1'b0; hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 1'b0;
      hz.id_use_rs2 = 1'b0; hz.id_rd = '0; hz.id_ruwr = 1'b0; hz.id_load = 1'b0;
      hz.ex_taken = 1'b0; hz.dm_req = 1'b0; hz.dm_ready = 1'b0;
      @(posedge clk);
      #1;

      //            rst va rs1 rs2 u1 u2 rd wr ld tk rq ry ctl  fa fb err stall
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST,  0, 0, 0, -1));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST,  0, 0, 0,  0));
      // forwarding: MEM beats WB, store in MEM leaves WB, x0 never forwards
      tbl.push_back(mk(0, 1, 1, 0, 1, 0, 5, 1, 0, 0, 0, 0, NORM, 0, 0, 0,  0));
      tbl.push_back(mk(0, 1, 2, 5, 1, 1, 5, 0, 0, 0, 0, 0, NORM, 0, 0, 0,  0));
      tbl.push_back(mk(0, 1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, NORM, 0, 2, 0,  0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 1, 1, 0,  0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, NORM, 0, 0, 0,  0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, NORM, 0, 0, 0,  0));
      tbl.push_back(mk(0, 1, 0, 0, 1, 1, 7, 1, 0, 0, 0, 0, NORM, 0, 0, 0,  0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, 0,  0));
      // load-use: lw x3 then add x4,x3,x1
      tbl.push_back(mk(0, 1, 1, 0, 1, 0, 3, 1, 1, 0, 0, 0, NORM, 0, 0, 0,  0));
      tbl.push_back(mk(0, 1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0, LU,   0, 0, 0,  0));
      tbl.push_back(mk(0, 1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0, NORM, 0, 0, 0,  1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 1, 0, 0,  1));
      // branch flush over a load-use hazard
      tbl.push_back(mk(0, 1, 2, 0, 1, 0, 8, 1, 1, 0, 0, 0, NORM, 0, 0, 0,  1));
      tbl.push_back(mk(0, 1, 8, 0, 1, 0, 9, 1, 0, 1, 0, 0, FL,   0, 0, 0,  1));
      // memory wait: 3 frozen cycles holding tracked state, ex_taken ignored
      tbl.push_back(mk(0, 1, 8, 0, 1, 0,10, 1, 0, 0, 0, 0, NORM, 0, 0, 0,  1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  1, 0, 0,  1));
      tbl.push_back(mk(0, 1, 8, 0, 1, 0,11, 1, 0, 1, 1, 0, FRZ,  1, 0, 0,  2));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  1, 0, 0,  3));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NORM, 1, 0, 0,  4));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, 0,  4));

      foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

      // timeout into ERR; late dm_ready and ex_taken change nothing
      for (int i = 0; i < 20; i++)
         step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 0, (i < 10) ? 0 : -1, 4 + i),
              $sformatf("tmo%0d", i));
      for (int j = 0; j < 3; j++)
         step(mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1, FRZ, 0, 0, 1, 24 + j),
              $sformatf("err%0d", j));
      step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RST,  0, 0, 0, -1), "err_rst");
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, 0,  0), "err_clr");
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NORM, 0, 0, 0,  0), "rdy_same_cycle");

      // reset during MEMWAIT with a load tracked in EX
      step(mk(0, 1, 1, 0, 1, 0, 3, 1, 1, 0, 0, 0, NORM, 0, 0, 0,  0), "mr_lw");
      step(mk(0, 1, 3, 0, 1, 0, 4, 1, 0, 0, 1, 0, FRZ,  0, 0, 0,  0), "mr_wait0");
      step(mk(0, 1, 3, 0, 1, 0, 4, 1, 0, 0, 1, 0, FRZ,  0, 0, 0,  1), "mr_wait1");
      step(mk(1, 1, 3, 0, 1, 0, 4, 1, 0, 1, 1, 0, RST,  0, 0, 0, -1), "mr_rst");
      step(mk(0, 1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 0, NORM, 0, 0, 0,  0), "mr_after");
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, 0,  0), "mr_fwd");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
